flow_ctrl_fsm_param: RTL

Parametrised flow-control controller for the FIFO-bank datapath. It watches the status flags of `NUM_FIFOS` FIFOs and drives per-channel pause and continue requests to the `NUM_UP` upstream sources. It also latches per-FIFO overflow errors until they are explicitly cleared. It sits between the FIFO status bus and the upstream arbiter, replacing the fixed 5-FIFO/4-source controller.

---
 rtl/flow_ctrl_fsm_param.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/flow_ctrl_fsm_param.sv
// Flow-control FSM: watches NUM_FIFOS status flags and drives NUM_UP upstream pause/continue requests.
// Latency: one edge from sampled flags to registered outputs (outputs derive from the next state).
// Backpressure: pausa held per channel while in PAUSE; enb=0 freezes all state; rst wins over everything.
//
// Ports:
//   clk, rst (sync, active-high), enb (advance enable)
//   iniciar (leave INIT), err_clear (leave ERROR, clear sticky flags)
//   almost_full/full/almost_empty/empty [NUM_FIFOS] : FIFO status flags
//   pausa/continuar [NUM_UP] : per-channel requests, channel i <-> FIFO i
//   error_full [NUM_FIFOS] : sticky overflow flags, idle, state_o, err_cnt (saturating)
module flow_ctrl_fsm_param #(
    parameter int NUM_FIFOS = 5,
    parameter int NUM_UP    = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic                 iniciar,
    input  logic                 err_clear,
    input  logic [NUM_FIFOS-1:0] almost_full,
    input  logic [NUM_FIFOS-1:0] full,
    input  logic [NUM_FIFOS-1:0] almost_empty,
    input  logic [NUM_FIFOS-1:0] empty,
    output logic [NUM_UP-1:0]    pausa,
    output logic [NUM_UP-1:0]    continuar,
    output logic [NUM_FIFOS-1:0] error_full,
    output logic                 idle,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [2:0] S_RESET    = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_ACTIVE   = 3'd3;
    localparam logic [2:0] S_PAUSE    = 3'd4;
    localparam logic [2:0] S_CONTINUE = 3'd5;
    localparam logic [2:0] S_ERROR    = 3'd6;

    logic [2:0]           r_state;
    logic [NUM_UP-1:0]    r_pausa;
    logic [NUM_UP-1:0]    r_continuar;
    logic [NUM_FIFOS-1:0] r_error_full;
    logic                 r_idle;
    logic [CNT_W-1:0]     r_err_cnt;

    logic [2:0]           w_next;
    logic [NUM_UP-1:0]    w_pausa;
    logic [NUM_UP-1:0]    w_continuar;
    logic [NUM_FIFOS-1:0] w_error_full;
    logic                 w_idle;
    logic [CNT_W-1:0]     w_err_cnt;

    logic w_any_full;
    logic w_any_afull;
    logic w_any_aempty;
    logic w_all_empty;

    assign w_any_full   = |full;
    assign w_any_afull  = |almost_full;
    assign w_any_aempty = |almost_empty;
    assign w_all_empty  = &empty;

    // State and output registers; enb=0 freezes everything, rst overrides enb.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_pausa      <= '0;
            r_continuar  <= '0;
            r_error_full <= '0;
            r_idle       <= 1'b0;
            r_err_cnt    <= '0;
        end else if (enb) begin
            r_state      <= w_next;
            r_pausa      <= w_pausa;
            r_continuar  <= w_continuar;
            r_error_full <= w_error_full;
            r_idle       <= w_idle;
            r_err_cnt    <= w_err_cnt;
        end
    end

    // Next-state logic; branches are in priority order.
    always_comb begin
        w_next = S_RESET;
        case (r_state)
            S_RESET:  w_next = S_INIT;
            S_INIT:   w_next = iniciar ? S_IDLE : S_INIT;
            S_IDLE: begin
                if (w_any_full)       w_next = S_ERROR;
                else if (w_all_empty) w_next = S_IDLE;
                else                  w_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_any_full)        w_next = S_ERROR;
                else if (w_any_afull)  w_next = S_PAUSE;
                else if (w_all_empty)  w_next = S_IDLE;
                else if (w_any_aempty) w_next = S_CONTINUE;
                else                   w_next = S_ACTIVE;
            end
            S_PAUSE: begin
                if (w_any_full)       w_next = S_ERROR;
                else if (w_any_afull) w_next = S_PAUSE;
                else                  w_next = S_ACTIVE;
            end
            S_CONTINUE: w_next = w_any_full ? S_ERROR : S_ACTIVE;
            // full is deliberately ignored here: only err_clear leaves ERROR.
            S_ERROR:    w_next = err_clear ? S_INIT : S_ERROR;
            default:    w_next = S_RESET;
        endcase
    end

    // Output logic: next register values from the next state and current inputs.
    always_comb begin
        w_pausa      = '0;
        w_continuar  = '0;
        w_idle       = 1'b0;
        w_error_full = r_error_full;
        w_err_cnt    = r_err_cnt;

        if (w_next == S_PAUSE)    w_pausa     = almost_full[NUM_UP-1:0];
        if (w_next == S_CONTINUE) w_continuar = almost_empty[NUM_UP-1:0];
        w_idle = (w_next == S_IDLE);

        if (w_next == S_ERROR) begin
            // Entry loads a fresh snapshot; dwelling accumulates.
            if (r_state == S_ERROR) w_error_full = r_error_full | full;
            else                    w_error_full = full;
        end else if (r_state == S_ERROR) begin
            // Only exit from ERROR is err_clear, which wipes the sticky flags.
            w_error_full = '0;
        end

        if ((w_next == S_ERROR) && (r_state != S_ERROR) && !(&r_err_cnt))
            w_err_cnt = r_err_cnt + CNT_W'(1);
    end

    assign state_o    = r_state;
    assign pausa      = r_pausa;
    assign continuar  = r_continuar;
    assign error_full = r_error_full;
    assign idle       = r_idle;
    assign err_cnt    = r_err_cnt;

endmodule
